// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the dual-core cache coherence controller.
//   word_t      32-bit data/address word
//   ramstate_t  RAM port status (FREE / BUSY / ACCESS / ERROR)
//   ccstate_t   coherence controller transaction states
//   reqclass_t  arbitration class of a granted request (icache or dcache)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        C2C,
        LOAD,
        WB,
        UPGRADE,
        IFETCH
    } ccstate_t;

    typedef enum logic {
        ICLASS,
        DCLASS
    } reqclass_t;

    localparam int unsigned BLK_WORDS_DEFAULT = 2;

endpackage

// File: rtl/cc_arbiter.sv
// cc_arbiter: picks which cache request the coherence controller serves next.
// dcache requests always beat icache requests; within a class the winner is
// either round-robin (CC_FAIR_ARB_EN defined) or fixed with CPU0 first.
// Ports:
//   CLK, RST    clock and synchronous active-high reset (fair build only)
//   grant_take  controller is idle and consumes the current grant (fair build only)
//   dreq, ireq  per-CPU dcache / icache request vectors
//   gnt_valid   some request is pending
//   gnt_idx     index of the winning CPU
//   gnt_class   class of the winning request
module cc_arbiter
    import cpu_types_pkg::*;
(
`ifdef CC_FAIR_ARB_EN
    input  logic       CLK,
    input  logic       RST,
    input  logic       grant_take,
`endif
    input  logic [1:0] dreq,
    input  logic [1:0] ireq,
    output logic       gnt_valid,
    output logic       gnt_idx,
    output reqclass_t  gnt_class
);

    logic [1:0] cls_req;

`ifdef CC_FAIR_ARB_EN
    // Points at the CPU preferred when both CPUs contend within a class.
    logic rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (grant_take && gnt_valid) begin
            rr_d = ~gnt_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        gnt_valid = (|dreq) | (|ireq);
        gnt_class = (|dreq) ? DCLASS : ICLASS;
        cls_req   = (|dreq) ? dreq : ireq;
`ifdef CC_FAIR_ARB_EN
        gnt_idx   = (cls_req == 2'b11) ? rr_q : cls_req[1];
`else
        gnt_idx   = ~cls_req[0];
`endif
    end

endmodule

// File: rtl/coherent_mem_ctrl.sv
// coherent_mem_ctrl: controller end of the dual-core cache coherence interface.
// Serves both CPUs' icaches and dcaches on a single RAM port, snoops and
// invalidates the other dcache, and forwards dirty blocks cache-to-cache while
// writing them back to RAM.
// Build option: CC_FAIR_ARB_EN selects round-robin arbitration within a request
// class; without it CPU0 has fixed priority over CPU1.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   iREN, dREN, dWEN         per-cache requests
//   iaddr, daddr, dstore     per-cache address / store data
//   ccwrite                  requester intends to modify the block
//   cctrans                  snoop reply: snooped cache will supply a dirty block
//   ramload, ramstate        RAM read data and status
//   iwait, dwait             per-cache stall, low for the cycle a word completes
//   iload, dload             per-cache load data
//   ccwait, ccinv            hold / invalidate to the snooped cache
//   ccsnoopaddr              snooped address
//   ccdone                   one-cycle transaction-complete pulse
//   ramaddr, ramstore        RAM address / write data
//   ramREN, ramWEN           RAM strobes
module coherent_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS     = 2,
    parameter int unsigned BLKWORDS = BLK_WORDS_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CPUS-1:0] iREN,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           iaddr       [CPUS],
    input  word_t           daddr       [CPUS],
    input  word_t           dstore      [CPUS],
    input  logic [CPUS-1:0] ccwrite,
    input  logic [CPUS-1:0] cctrans,
    input  word_t           ramload,
    input  ramstate_t       ramstate,
    output logic [CPUS-1:0] iwait,
    output logic [CPUS-1:0] dwait,
    output word_t           iload       [CPUS],
    output word_t           dload       [CPUS],
    output logic [CPUS-1:0] ccwait,
    output logic [CPUS-1:0] ccinv,
    output word_t           ccsnoopaddr [CPUS],
    output logic [CPUS-1:0] ccdone,
    output word_t           ramaddr,
    output word_t           ramstore,
    output logic            ramREN,
    output logic            ramWEN
);

    if (CPUS != 2) begin : g_cpus_check
        $error("coherent_mem_ctrl supports CPUS == 2 only");
    end

    localparam int unsigned WCW = $clog2(BLKWORDS) + 1;

    ccstate_t       state_q, state_d;
    logic           g_q, g_d;
    logic [WCW-1:0] word_q, word_d;
    // Second cycle of SNOOP, or the ccdone cycle of WB/LOAD/C2C/UPGRADE.
    logic           tail_q, tail_d;

    logic           o;
    logic           last_word;
    logic           acc;

    logic           gnt_valid;
    logic           gnt_idx;
    reqclass_t      gnt_class;

    cc_arbiter u_arb (
`ifdef CC_FAIR_ARB_EN
        .CLK        (CLK),
        .RST        (RST),
        .grant_take (state_q == IDLE),
`endif
        .dreq       (dREN | dWEN | ccwrite),
        .ireq       (iREN),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_class  (gnt_class)
    );

    assign o         = ~g_q;
    assign last_word = (word_q == WCW'(BLKWORDS - 1));
    assign acc       = (ramstate == ACCESS);

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        word_d   = word_q;
        tail_d   = tail_q;

        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ccdone   = '0;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        for (int i = 0; i < int'(CPUS); i++) begin
            iload[i]       = ramload;
            dload[i]       = ramload;
            ccsnoopaddr[i] = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    g_d    = gnt_idx;
                    word_d = '0;
                    tail_d = 1'b0;
                    if (gnt_class == DCLASS) begin
                        if (dWEN[gnt_idx]) begin
                            state_d = WB;
                        end else if (dREN[gnt_idx]) begin
                            state_d = SNOOP;
                        end else begin
                            state_d = UPGRADE;
                        end
                    end else begin
                        state_d = IFETCH;
                    end
                end
            end

            SNOOP: begin
                ccsnoopaddr[o] = daddr[g_q];
                ccwait[o]      = 1'b1;
                if (!tail_q) begin
                    ccinv[o] = ccwrite[g_q];
                    tail_d   = 1'b1;
                end else begin
                    tail_d  = 1'b0;
                    state_d = cctrans[o] ? C2C : LOAD;
                end
            end

            C2C: begin
                if (!tail_q) begin
                    ccsnoopaddr[o] = daddr[g_q];
                    ccwait[o]      = 1'b1;
                    ramWEN         = 1'b1;
                    ramaddr        = daddr[o];
                    ramstore       = dstore[o];
                    dload[g_q]     = dstore[o];
                    if (acc) begin
                        dwait[g_q] = 1'b0;
                        dwait[o]   = 1'b0;
                        word_d     = word_q + WCW'(1);
                        tail_d     = last_word;
                    end
                end else begin
                    ccdone[g_q] = 1'b1;
                    ccdone[o]   = 1'b1;
                    tail_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            LOAD: begin
                if (!tail_q) begin
                    ccsnoopaddr[o] = daddr[g_q];
                    ccwait[o]      = 1'b1;
                    ramREN         = 1'b1;
                    ramaddr        = daddr[g_q];
                    if (acc) begin
                        dwait[g_q] = 1'b0;
                        word_d     = word_q + WCW'(1);
                        tail_d     = last_word;
                    end
                end else begin
                    ccdone[g_q] = 1'b1;
                    tail_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            WB: begin
                if (!tail_q) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[g_q];
                    ramstore = dstore[g_q];
                    if (acc) begin
                        dwait[g_q] = 1'b0;
                        word_d     = word_q + WCW'(1);
                        tail_d     = last_word;
                    end
                end else begin
                    ccdone[g_q] = 1'b1;
                    tail_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            UPGRADE: begin
                if (!tail_q) begin
                    ccsnoopaddr[o] = daddr[g_q];
                    ccwait[o]      = 1'b1;
                    ccinv[o]       = 1'b1;
                    tail_d         = 1'b1;
                end else begin
                    ccdone[g_q] = 1'b1;
                    tail_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[g_q];
                if (acc) begin
                    iwait[g_q] = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            word_q  <= '0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            word_q  <= word_d;
            tail_q  <= tail_d;
        end
    end

`ifndef SYNTHESIS
    // A requester must hold its request until its block has fully moved.
    a_dread_held : assert property (@(posedge CLK) disable iff (RST)
        (state_q == SNOOP || ((state_q == LOAD || state_q == C2C) && !tail_q))
        |-> dREN[g_q]);
    a_dwrite_held : assert property (@(posedge CLK) disable iff (RST)
        (state_q == WB && !tail_q) |-> dWEN[g_q]);
    a_iread_held : assert property (@(posedge CLK) disable iff (RST)
        (state_q == IFETCH) |-> iREN[g_q]);
`endif

endmodule

// File: tb/tb_coherent_mem_ctrl.sv
// Directed bench for coherent_mem_ctrl: inputs change on the falling edge and
// outputs are compared 1 time unit later, well clear of the rising edge.
module tb_coherent_mem_ctrl;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] iREN, dREN, dWEN, ccwrite, cctrans;
    word_t      iaddr [2];
    word_t      daddr [2];
    word_t      dstore [2];
    word_t      ramload;
    ramstate_t  ramstate;
    logic [1:0] iwait, dwait, ccwait, ccinv, ccdone;
    word_t      iload [2];
    word_t      dload [2];
    word_t      ccsnoopaddr [2];
    word_t      ramaddr, ramstore;
    logic       ramREN, ramWEN;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    coherent_mem_ctrl #(.CPUS(2), .BLKWORDS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ccdone(ccdone),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge CLK);
    endtask

    initial begin
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        for (int i = 0; i < 2; i++) begin
            iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0;
        end
        ramload = 32'h1234_5678; ramstate = FREE;

        // Reset values
        nxt(); nxt(); RST = 1'b0; #1;
        chk("rst_iwait", {30'd0, iwait}, 32'h3);
        chk("rst_dwait", {30'd0, dwait}, 32'h3);
        chk("rst_cc", {26'd0, ccwait, ccinv, ccdone}, 32'h0);
        chk("rst_ramstb", {30'd0, ramREN, ramWEN}, 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_snoopaddr", ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
        chk("rst_iload_pass", iload[0], 32'h1234_5678);
        chk("rst_dload_pass", dload[1], 32'h1234_5678);

        // Instruction fetch with two BUSY cycles
        nxt(); iREN = 2'b01; iaddr[0] = 32'h100; ramstate = BUSY;
        nxt(); #1;
        chk("if_ren", {31'd0, ramREN}, 32'h1);
        chk("if_addr", ramaddr, 32'h100);
        chk("if_busy1_iwait", {30'd0, iwait}, 32'h3);
        nxt(); #1;
        chk("if_busy2_iwait", {30'd0, iwait}, 32'h3);
        nxt(); ramstate = ACCESS; ramload = 32'hDEAD_BEEF; #1;
        chk("if_ack_iwait", {30'd0, iwait}, 32'h2);
        chk("if_iload", iload[0], 32'hDEAD_BEEF);
        nxt(); iREN = '0; ramstate = FREE; #1;
        chk("if_done_iwait", {30'd0, iwait}, 32'h3);
        chk("if_done_ren", {31'd0, ramREN}, 32'h0);
        chk("if_no_ccdone", {30'd0, ccdone}, 32'h0);

        // Read miss by CPU1, no dirty copy elsewhere -> RAM load
        nxt(); dREN = 2'b10; daddr[1] = 32'h200;
        nxt(); #1;
        chk("ld_snoopaddr", ccsnoopaddr[0], 32'h200);
        chk("ld_ccwait", {30'd0, ccwait}, 32'h1);
        chk("ld_ccinv", {30'd0, ccinv}, 32'h0);
        nxt(); #1;
        chk("ld_snoop2_noram", {30'd0, ramREN, ramWEN}, 32'h0);
        nxt(); ramstate = ACCESS; ramload = 32'h1111_0000; #1;
        chk("ld_w0_ren", {31'd0, ramREN}, 32'h1);
        chk("ld_w0_addr", ramaddr, 32'h200);
        chk("ld_w0_dwait", {30'd0, dwait}, 32'h1);
        chk("ld_w0_dload", dload[1], 32'h1111_0000);
        nxt(); daddr[1] = 32'h204; ramstate = BUSY; #1;
        chk("ld_busy_dwait", {30'd0, dwait}, 32'h3);
        chk("ld_busy_addr", ramaddr, 32'h204);
        chk("ld_busy_ccwait", {30'd0, ccwait}, 32'h1);
        nxt(); ramstate = ACCESS; ramload = 32'h1111_0004; #1;
        chk("ld_w1_dwait", {30'd0, dwait}, 32'h1);
        chk("ld_w1_dload", dload[1], 32'h1111_0004);
        nxt(); ramstate = FREE; #1;
        chk("ld_ccdone", {30'd0, ccdone}, 32'h2);
        chk("ld_done_dwait", {30'd0, dwait}, 32'h3);
        dREN = '0;
        nxt(); #1;
        chk("ld_ccdone_pulse", {30'd0, ccdone}, 32'h0);

        // BusRdX by CPU0, CPU1 holds dirty block -> cache-to-cache + write-back
        nxt(); dREN = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h400; cctrans = 2'b10;
        nxt(); #1;
        chk("c2c_ccinv", {30'd0, ccinv}, 32'h2);
        chk("c2c_snoopaddr", ccsnoopaddr[1], 32'h400);
        nxt();
        nxt(); dWEN = 2'b10; daddr[1] = 32'h400; dstore[1] = 32'hAAAA_0000;
        ramstate = ACCESS; #1;
        chk("c2c_w0_wen", {31'd0, ramWEN}, 32'h1);
        chk("c2c_w0_addr", ramaddr, 32'h400);
        chk("c2c_w0_store", ramstore, 32'hAAAA_0000);
        chk("c2c_w0_dload", dload[0], 32'hAAAA_0000);
        chk("c2c_w0_dwait", {30'd0, dwait}, 32'h0);
        nxt(); daddr[1] = 32'h404; dstore[1] = 32'hAAAA_0004; #1;
        chk("c2c_w1_wen", {31'd0, ramWEN}, 32'h1);
        chk("c2c_w1_store", ramstore, 32'hAAAA_0004);
        chk("c2c_w1_dload", dload[0], 32'hAAAA_0004);
        nxt(); ramstate = FREE; #1;
        chk("c2c_ccdone", {30'd0, ccdone}, 32'h3);
        dWEN = '0; dREN = '0; ccwrite = '0; cctrans = '0;
        nxt(); #1;
        chk("c2c_ccdone_pulse", {30'd0, ccdone}, 32'h0);

        // Upgrade by CPU1: invalidate only, no RAM traffic
        nxt(); ccwrite = 2'b10; daddr[1] = 32'h300;
        nxt(); #1;
        chk("up_ccinv", {30'd0, ccinv}, 32'h1);
        chk("up_snoopaddr", ccsnoopaddr[0], 32'h300);
        chk("up_noram", {30'd0, ramREN, ramWEN}, 32'h0);
        chk("up_no_early_done", {30'd0, ccdone}, 32'h0);
        nxt(); #1;
        chk("up_ccdone", {30'd0, ccdone}, 32'h2);
        chk("up_ccinv_off", {30'd0, ccinv}, 32'h0);
        ccwrite = '0;

        // Three simultaneous requests: dcache1, then icache0, then icache1
        nxt(); iREN = 2'b11; iaddr[0] = 32'h500; iaddr[1] = 32'h600;
        dREN = 2'b10; daddr[1] = 32'h700;
        nxt(); #1;
        chk("arb_d_first", ccsnoopaddr[0], 32'h700);
        chk("arb_no_ifetch", {31'd0, ramREN}, 32'h0);
        nxt();
        nxt(); ramstate = ACCESS; #1;
        chk("arb_ld_addr", ramaddr, 32'h700);
        nxt();
        nxt(); ramstate = FREE; #1;
        chk("arb_ld_done", {30'd0, ccdone}, 32'h2);
        dREN = '0;
        nxt();
        nxt(); ramstate = ACCESS; #1;
        chk("arb_i0_addr", ramaddr, 32'h500);
        chk("arb_i0_iwait", {30'd0, iwait}, 32'h2);
        nxt(); iREN = 2'b10; ramstate = FREE;
        nxt(); ramstate = ACCESS; #1;
        chk("arb_i1_addr", ramaddr, 32'h600);
        chk("arb_i1_iwait", {30'd0, iwait}, 32'h1);
        nxt(); iREN = '0; ramstate = FREE;

        // Write-back by CPU0
        nxt(); dWEN = 2'b01; daddr[0] = 32'h800; dstore[0] = 32'hC0DE_0000;
        nxt(); ramstate = ACCESS; #1;
        chk("wb_w0_wen", {31'd0, ramWEN}, 32'h1);
        chk("wb_w0_addr", ramaddr, 32'h800);
        chk("wb_w0_store", ramstore, 32'hC0DE_0000);
        chk("wb_w0_dwait", {30'd0, dwait}, 32'h2);
        nxt(); daddr[0] = 32'h804; dstore[0] = 32'hC0DE_0004; #1;
        chk("wb_w1_store", ramstore, 32'hC0DE_0004);
        chk("wb_w1_snoop_quiet", {30'd0, ccwait}, 32'h0);
        nxt(); ramstate = FREE; #1;
        chk("wb_ccdone", {30'd0, ccdone}, 32'h1);
        dWEN = '0;

        // Reset during the first word of a LOAD aborts it
        nxt(); dREN = 2'b01; daddr[0] = 32'h900;
        nxt();
        nxt();
        nxt(); ramstate = BUSY; #1;
        chk("rl_in_load", {31'd0, ramREN}, 32'h1);
        RST = 1'b1;
        nxt(); RST = 1'b0; dREN = '0; ramstate = ACCESS; #1;
        chk("rl_dwait", {30'd0, dwait}, 32'h3);
        chk("rl_ccdone", {30'd0, ccdone}, 32'h0);
        chk("rl_ramstb", {30'd0, ramREN, ramWEN}, 32'h0);
        chk("rl_ccwait", {30'd0, ccwait}, 32'h0);
        nxt(); ramstate = FREE; #1;
        chk("rl_idle_ccdone", {30'd0, ccdone}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
